// File: rtl/fila_pkg.sv
// fila_pkg: shared types and constants for the FILA access scheduler.
//   ctrl_state_t : scheduler FSM states
//   req_id_t     : requester identities, also the round-robin order
//   rr_next()    : successor of a requester in round-robin order
package fila_pkg;

  localparam int FILA_DW    = 8;
  localparam int FILA_DEPTH = 8;
  localparam int FILA_LAT   = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} ctrl_state_t;
  typedef enum logic [1:0] {PROD0, PROD1, CONS} req_id_t;

  function automatic req_id_t rr_next(input req_id_t id);
    case (id)
      PROD0:   return PROD1;
      PROD1:   return CONS;
      default: return PROD0;
    endcase
  endfunction

endpackage

// File: rtl/fila_rr_arb.sv
// fila_rr_arb: combinational round-robin pick among PROD0, PROD1 and CONS.
//   eligible    in  3  bit0 PROD0, bit1 PROD1, bit2 CONS
//   last        in     most recent winner; search starts at its successor
//   grant_valid out 1  some requester is eligible
//   grant_id    out    winning requester (PROD0 when grant_valid is low)
module fila_rr_arb
  import fila_pkg::*;
(
  input  logic [2:0] eligible,
  input  req_id_t    last,
  output logic       grant_valid,
  output req_id_t    grant_id
);

  function automatic logic bit_of(input logic [2:0] v, input req_id_t id);
    case (id)
      PROD0:   return v[0];
      PROD1:   return v[1];
      default: return v[2];
    endcase
  endfunction

  req_id_t cand0, cand1, cand2;

  always_comb begin
    cand0       = rr_next(last);
    cand1       = rr_next(cand0);
    cand2       = rr_next(cand1);
    grant_valid = 1'b1;
    grant_id    = PROD0;
    if (bit_of(eligible, cand0))      grant_id = cand0;
    else if (bit_of(eligible, cand1)) grant_id = cand1;
    else if (bit_of(eligible, cand2)) grant_id = cand2;
    else                              grant_valid = 1'b0;
  end

endmodule

// File: rtl/fila_ctrl.sv
// fila_ctrl: shares the FILA queue between two producers and one consumer.
// One FILA access in flight at a time; round-robin arbitration; enqueues are
// never issued while FILA is full, dequeues never while it is empty.
//   clock_10KHz, reset (async, active low)
//   p0_req/p0_data/p0_ack, p1_req/p1_data/p1_ack : producer handshakes
//   c_req/c_ack/c_data                            : consumer handshake
//   fila_data/fila_enq/fila_deq                   : strobes and data to FILA
//   fila_dout/fila_len                            : status and data from FILA
//   busy, full, empty                             : status
//
// state | meaning
// IDLE  | arbitrate eligible requesters, latch grant and producer data
// ISSUE | one-cycle enqueue/dequeue strobe to FILA
// WAIT  | let FILA settle for FILA_LAT cycles
// ACK   | one-cycle ack to the granted requester
module fila_ctrl
  import fila_pkg::*;
#(
  parameter int DW       = FILA_DW,
  parameter int DEPTH    = FILA_DEPTH,
  parameter int FILA_LAT = fila_pkg::FILA_LAT
) (
  input  logic          clock_10KHz,
  input  logic          reset,
  input  logic          p0_req,
  input  logic [DW-1:0] p0_data,
  output logic          p0_ack,
  input  logic          p1_req,
  input  logic [DW-1:0] p1_data,
  output logic          p1_ack,
  input  logic          c_req,
  output logic          c_ack,
  output logic [DW-1:0] c_data,
  output logic [DW-1:0] fila_data,
  output logic          fila_enq,
  output logic          fila_deq,
  input  logic [DW-1:0] fila_dout,
  input  logic [3:0]    fila_len,
  output logic          busy,
  output logic          full,
  output logic          empty
);

  localparam int          CW       = $clog2(FILA_LAT) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(FILA_LAT - 1);
  localparam logic [3:0]  DEPTH_L  = 4'(DEPTH);

  ctrl_state_t   state;
  req_id_t       last;
  req_id_t       gid;
  logic [CW-1:0] cnt;
  logic [2:0]    eligible;
  logic          grant_valid;
  req_id_t       grant_id;

  assign full  = (fila_len == DEPTH_L);
  assign empty = (fila_len == 4'd0);
  assign busy  = (state != IDLE);

  assign eligible = {c_req  & (fila_len != 4'd0),
                     p1_req & (fila_len < DEPTH_L),
                     p0_req & (fila_len < DEPTH_L)};

  fila_rr_arb u_arb (
    .eligible    (eligible),
    .last        (last),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clock_10KHz or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last      <= CONS;
      gid       <= PROD0;
      cnt       <= '0;
      fila_data <= '0;
      fila_enq  <= 1'b0;
      fila_deq  <= 1'b0;
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      c_ack     <= 1'b0;
      c_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            gid   <= grant_id;
            last  <= grant_id;
            state <= ISSUE;
            // strobe is set here so it is high for exactly the ISSUE cycle
            case (grant_id)
              PROD0: begin
                fila_data <= p0_data;
                fila_enq  <= 1'b1;
              end
              PROD1: begin
                fila_data <= p1_data;
                fila_enq  <= 1'b1;
              end
              default: fila_deq <= 1'b1;
            endcase
          end
        end
        ISSUE: begin
          fila_enq <= 1'b0;
          fila_deq <= 1'b0;
          cnt      <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (cnt == LAST_CNT) begin
            state <= ACK;
            case (gid)
              PROD0: p0_ack <= 1'b1;
              PROD1: p1_ack <= 1'b1;
              default: begin
                c_ack  <= 1'b1;
                c_data <= fila_dout;
              end
            endcase
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ACK: begin
          p0_ack <= 1'b0;
          p1_ack <= 1'b0;
          c_ack  <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fila_ctrl.sv
`timescale 1us/1ns
module tb_fila_ctrl;
  import fila_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int LAT   = 3;

  logic          clock_10KHz = 1'b0;
  logic          reset = 1'b0;
  logic          p0_req = 1'b0, p1_req = 1'b0, c_req = 1'b0;
  logic [DW-1:0] p0_data = '0, p1_data = '0;
  logic          p0_ack, p1_ack, c_ack;
  logic [DW-1:0] c_data, fila_data;
  logic          fila_enq, fila_deq;
  logic [DW-1:0] fila_dout;
  logic [3:0]    fila_len;
  logic          busy, full, empty;

  always #50 clock_10KHz = ~clock_10KHz;

  fila_ctrl dut (
    .clock_10KHz (clock_10KHz),
    .reset       (reset),
    .p0_req      (p0_req),
    .p0_data     (p0_data),
    .p0_ack      (p0_ack),
    .p1_req      (p1_req),
    .p1_data     (p1_data),
    .p1_ack      (p1_ack),
    .c_req       (c_req),
    .c_ack       (c_ack),
    .c_data      (c_data),
    .fila_data   (fila_data),
    .fila_enq    (fila_enq),
    .fila_deq    (fila_deq),
    .fila_dout   (fila_dout),
    .fila_len    (fila_len),
    .busy        (busy),
    .full        (full),
    .empty       (empty)
  );

  typedef struct {
    int          id;    // 0 PROD0, 1 PROD1, 2 CONS
    logic [7:0]  data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] ref_q[$];
  int         ref_last = 2;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Behavioural FILA: a plain queue, cleared by reset
  logic [7:0] fq[$];
  always @(posedge clock_10KHz or negedge reset) begin
    if (!reset) begin
      fq.delete();
      fila_len  <= 4'd0;
      fila_dout <= '0;
    end else begin
      if (fila_enq) fq.push_back(fila_data);
      if (fila_deq && fq.size() > 0) fila_dout <= fq.pop_front();
      fila_len <= 4'(fq.size());
    end
  end

  // Monitor: pops the scoreboard on every ack, checks strobes against its head
  int   cyc = 0;
  int   last_strobe = -1;
  exp_t m_e;
  always @(negedge clock_10KHz) begin
    cyc++;
    if (!reset) begin
      last_strobe = -1;
    end else begin
      if (fila_enq || fila_deq) begin
        chk("single_strobe", int'(fila_enq && fila_deq), 0);
        if (last_strobe >= 0)
          chk("strobe_gap_min", int'((cyc - last_strobe) >= LAT + 2), 1);
        last_strobe = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else if (exp_q[0].id == 2) begin
          chk("deq_for_cons", int'(fila_deq), 1);
        end else begin
          chk("enq_for_prod", int'(fila_enq), 1);
          chk("enq_data", int'(fila_data), int'(exp_q[0].data));
        end
      end
      if ({c_ack, p1_ack, p0_ack} != 3'b000) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", int'({c_ack, p1_ack, p0_ack}), 0);
        end else begin
          m_e = exp_q.pop_front();
          chk("ack_id", int'({c_ack, p1_ack, p0_ack}), 1 << m_e.id);
          if (m_e.id == 2) chk("c_data", int'(c_data), int'(m_e.data));
        end
      end
    end
  end

  function automatic bit elig(input int id);
    if (id == 2) return ref_q.size() > 0;
    return ref_q.size() < DEPTH;
  endfunction

  // Predicts the grant sequence from the round-robin rules, pushes it to the
  // scoreboard, then drives the requests until that many acks have appeared.
  task automatic run_burst(input logic [2:0] mask, input logic [2:0] hold,
                           input logic [7:0] d0, input logic [7:0] d1, input int nmax);
    logic [2:0] pend;
    int nexp, seen, budget;
    pend = mask;
    nexp = 0;
    seen = 0;
    while (nexp < nmax) begin
      int   w;
      exp_t e;
      w = -1;
      for (int k = 1; k <= 3; k++) begin
        int id;
        id = (ref_last + k) % 3;
        if (w < 0 && pend[id] && elig(id)) w = id;
      end
      if (w < 0) break;
      e.id = w;
      if (w == 0)      e.data = d0;
      else if (w == 1) e.data = d1;
      else             e.data = ref_q.pop_front();
      if (w < 2) ref_q.push_back(e.data);
      exp_q.push_back(e);
      ref_last = w;
      nexp++;
      if (!hold[w]) pend[w] = 1'b0;
    end
    p0_data = d0;
    p1_data = d1;
    p0_req  = mask[0];
    p1_req  = mask[1];
    c_req   = mask[2];
    budget  = nexp * (LAT + 5) + 20;
    for (int i = 0; i < budget && seen < nexp; i++) begin
      @(negedge clock_10KHz);
      if (p0_ack) begin seen++; if (!hold[0]) p0_req = 1'b0; end
      if (p1_ack) begin seen++; if (!hold[1]) p1_req = 1'b0; end
      if (c_ack)  begin seen++; if (!hold[2]) c_req  = 1'b0; end
      if (seen >= nexp) begin
        p0_req = 1'b0;
        p1_req = 1'b0;
        c_req  = 1'b0;
      end
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    c_req  = 1'b0;
    chk("burst_ack_count", seen, nexp);
    for (int i = 0; i < 20 && busy; i++) @(negedge clock_10KHz);
    repeat (3) @(negedge clock_10KHz);
    chk("burst_len", int'(fila_len), ref_q.size());
    chk("burst_full", int'(full), int'(ref_q.size() == DEPTH));
    chk("burst_empty", int'(empty), int'(ref_q.size() == 0));
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt_bad, len0;
    exp_t e;

    // reset values
    repeat (3) @(negedge clock_10KHz);
    #1;
    chk("rst_acks", int'({p0_ack, p1_ack, c_ack}), 0);
    chk("rst_strobes", int'({fila_enq, fila_deq}), 0);
    chk("rst_fila_data", int'(fila_data), 0);
    chk("rst_c_data", int'(c_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_empty", int'(empty), 1);
    @(negedge clock_10KHz);
    reset = 1'b1;
    @(negedge clock_10KHz);

    // consumer stalls on empty, then p0 enqueue of 0x3C lets it through
    run_burst(3'b100, 3'b000, 8'h00, 8'h00, 100);
    run_burst(3'b101, 3'b000, 8'h3C, 8'h00, 100);
    chk("empty_after_3c", int'(empty), 1);

    // single enqueue latency
    @(negedge clock_10KHz);
    p0_data = 8'hA5;
    p0_req  = 1'b1;
    e.id = 0; e.data = 8'hA5;
    exp_q.push_back(e);
    ref_q.push_back(8'hA5);
    ref_last = 0;
    @(negedge clock_10KHz);
    chk("lat_enq_cycle1", int'(fila_enq), 1);
    chk("lat_fila_data", int'(fila_data), 8'hA5);
    @(negedge clock_10KHz);
    chk("lat_enq_cycle2", int'(fila_enq), 0);
    repeat (2) @(negedge clock_10KHz);
    chk("lat_no_ack_cycle4", int'(p0_ack), 0);
    @(negedge clock_10KHz);
    chk("lat_ack_cycle5", int'(p0_ack), 1);
    p0_req = 1'b0;
    repeat (3) @(negedge clock_10KHz);
    chk("lat_len", int'(fila_len), 1);

    // reset in the middle of WAIT
    p0_data = 8'h5A;
    p0_req  = 1'b1;
    e.id = 0; e.data = 8'h5A;
    exp_q.push_back(e);
    repeat (3) @(negedge clock_10KHz);
    reset  = 1'b0;
    p0_req = 1'b0;
    #1;
    chk("midrst_acks", int'({p0_ack, p1_ack, c_ack}), 0);
    chk("midrst_strobes", int'({fila_enq, fila_deq}), 0);
    chk("midrst_busy", int'(busy), 0);
    exp_q.delete();
    ref_q.delete();
    ref_last = 2;
    repeat (2) @(negedge clock_10KHz);
    reset = 1'b1;
    @(negedge clock_10KHz);

    // PROD0 first after reset, then build len=2 with last=CONS
    run_burst(3'b011, 3'b000, 8'h21, 8'h22, 100);
    run_burst(3'b001, 3'b000, 8'h23, 8'h00, 100);
    run_burst(3'b100, 3'b000, 8'h00, 8'h00, 100);

    // all three held: PROD0, PROD1, CONS, PROD0
    run_burst(3'b111, 3'b111, 8'h31, 8'h32, 4);

    // producer holding req through ack writes twice
    len0 = int'(fila_len);
    run_burst(3'b001, 3'b001, 8'h44, 8'h00, 2);
    chk("hold_len_delta", int'(fila_len) - len0, 2);

    // drain, then fill with 0x11..0x18
    run_burst(3'b100, 3'b100, 8'h00, 8'h00, ref_q.size());
    for (int i = 0; i < DEPTH; i++) run_burst(3'b001, 3'b000, 8'(8'h11 + i), 8'h00, 100);
    chk("fill_full", int'(full), 1);

    // p1 stalls while full
    p1_data = 8'h99;
    p1_req  = 1'b1;
    cnt_bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock_10KHz);
      if (fila_enq || p1_ack) cnt_bad++;
    end
    chk("full_stall", cnt_bad, 0);
    run_burst(3'b110, 3'b000, 8'h00, 8'h99, 100);

    // randomized bursts
    for (int n = 0; n < 30; n++)
      run_burst(3'($urandom_range(1, 7)), 3'b000, 8'($urandom), 8'($urandom), 100);

    repeat (10) @(negedge clock_10KHz);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
